// File: rtl/display_scan_if.sv
// display_scan_if
//   Bundles the load/glyph inputs and the scan outputs of display_scan.
//   master : drives load, glyphs, dp_in, blink_in; observes the display outputs
//   slave  : the display_scan side
//   Signals:
//     load        single-cycle capture strobe
//     glyphs      5 bits per digit, digit i at [5i+4:5i], digit 0 rightmost
//     dp_in       decimal point request per digit
//     blink_in    blink enable per digit
//     seg         segments {a..g}, a = MSB, polarity applied
//     dp          decimal point segment, polarity applied
//     an          digit enables, polarity applied
//     frame_start one-cycle pulse as the digit 0 slot is presented
//     pending     shadow bank holds uncommitted data
interface display_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [5*NUM_DIGITS-1:0]   glyphs;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [NUM_DIGITS-1:0]     blink_in;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_start;
    logic                      pending;

    modport master (
        output load, glyphs, dp_in, blink_in,
        input  seg, dp, an, frame_start, pending
    );

    modport slave (
        input  load, glyphs, dp_in, blink_in,
        output seg, dp, an, frame_start, pending
    );
endinterface

// File: rtl/display_scan.sv
// display_scan
//   Time-multiplexed seven-segment driver. Glyphs are captured into a shadow
//   bank on load and committed to the active bank at the frame boundary, so
//   a single frame never mixes old and new data. Each digit slot starts with
//   a blanking dead-time before the digit is lit.
//   Ports:
//     i_clock  system clock, rising edge
//     i_reset  synchronous, active-high
//     io_disp  display_scan_if slave modport (load/glyph inputs, scan outputs)
module display_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int BLINK_FRAMES   = 100,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic            i_clock,
    input  logic            i_reset,
    display_scan_if.slave   io_disp
);

    localparam int CW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int IW = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BFC_LAST  = BW'(BLINK_FRAMES - 1);

    // Inactive output levels; XOR with these applies polarity after decode.
    localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [4:0]            GLYPH_BLANK = 5'd18;

    logic [CW-1:0]                 r_cnt;
    logic [IW-1:0]                 r_idx;
    logic [BW-1:0]                 r_bfc;
    logic                          r_blink_on;
    logic                          r_pending;

    logic [NUM_DIGITS-1:0][4:0]    r_sh_glyph;
    logic [NUM_DIGITS-1:0]         r_sh_dp;
    logic [NUM_DIGITS-1:0]         r_sh_blink;
    logic [NUM_DIGITS-1:0][4:0]    r_act_glyph;
    logic [NUM_DIGITS-1:0]         r_act_dp;
    logic [NUM_DIGITS-1:0]         r_act_blink;

    logic [6:0]                    r_seg;
    logic                          r_dp;
    logic [NUM_DIGITS-1:0]         r_an;
    logic                          r_frame_start;

    logic                          w_cnt_wrap;
    logic                          w_frame;
    logic                          w_lit;
    logic                          w_show;
    logic [NUM_DIGITS-1:0]         w_onehot;
    logic [6:0]                    w_seg_log;
    logic                          w_dp_log;
    logic [NUM_DIGITS-1:0]         w_an_log;

    function automatic logic [6:0] decode(input logic [4:0] g);
        logic [6:0] s;
        case (g)
            5'd0:    s = 7'b1111110;
            5'd1:    s = 7'b0110000;
            5'd2:    s = 7'b1101101;
            5'd3:    s = 7'b1111001;
            5'd4:    s = 7'b0110011;
            5'd5:    s = 7'b1011011;
            5'd6:    s = 7'b1011111;
            5'd7:    s = 7'b1110000;
            5'd8:    s = 7'b1111111;
            5'd9:    s = 7'b1111011;
            5'd10:   s = 7'b1100111;
            5'd11:   s = 7'b1011011;
            5'd12:   s = 7'b0111110;
            5'd13:   s = 7'b1001111;
            5'd14:   s = 7'b0000101;
            5'd15:   s = 7'b0011111;
            5'd16:   s = 7'b0001101;
            5'd17:   s = 7'b1011110;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    always_comb begin
        w_cnt_wrap = (r_cnt == CNT_LAST);
        w_frame    = w_cnt_wrap && (r_idx == IDX_LAST);
        w_lit      = (r_cnt >= CNT_BLANK);
        // Blink-off keeps the anode driven so the scan duty cycle is unchanged.
        w_show     = !(r_act_blink[r_idx] && !r_blink_on);

        w_onehot        = '0;
        w_onehot[r_idx] = 1'b1;

        w_an_log  = '0;
        w_seg_log = '0;
        w_dp_log  = 1'b0;
        if (w_lit) begin
            w_an_log = w_onehot;
            if (w_show) begin
                w_seg_log = decode(r_act_glyph[r_idx]);
                w_dp_log  = r_act_dp[r_idx];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_bfc         <= '0;
            r_blink_on    <= 1'b1;
            r_pending     <= 1'b0;
            r_sh_glyph    <= {NUM_DIGITS{GLYPH_BLANK}};
            r_sh_dp       <= '0;
            r_sh_blink    <= '0;
            r_act_glyph   <= {NUM_DIGITS{GLYPH_BLANK}};
            r_act_dp      <= '0;
            r_act_blink   <= '0;
            r_seg         <= SEG_OFF;
            r_dp          <= SEG_ACTIVE_LOW;
            r_an          <= AN_OFF;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
            if (w_cnt_wrap) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end

            if (w_frame) begin
                if (r_bfc == BFC_LAST) begin
                    r_bfc      <= '0;
                    r_blink_on <= !r_blink_on;
                end else begin
                    r_bfc <= r_bfc + 1'b1;
                end
            end

            // A load on the boundary cycle bypasses the shadow and commits
            // directly, so it supersedes any older pending data.
            if (io_disp.load) begin
                r_sh_glyph <= io_disp.glyphs;
                r_sh_dp    <= io_disp.dp_in;
                r_sh_blink <= io_disp.blink_in;
                if (w_frame) begin
                    r_act_glyph <= io_disp.glyphs;
                    r_act_dp    <= io_disp.dp_in;
                    r_act_blink <= io_disp.blink_in;
                end
                r_pending <= !w_frame;
            end else if (w_frame && r_pending) begin
                r_act_glyph <= r_sh_glyph;
                r_act_dp    <= r_sh_dp;
                r_act_blink <= r_sh_blink;
                r_pending   <= 1'b0;
            end

            r_seg         <= w_seg_log ^ SEG_OFF;
            r_dp          <= w_dp_log ^ SEG_ACTIVE_LOW;
            r_an          <= w_an_log ^ AN_OFF;
            r_frame_start <= (r_cnt == '0) && (r_idx == '0);
        end
    end

    assign io_disp.seg         = r_seg;
    assign io_disp.dp          = r_dp;
    assign io_disp.an          = r_an;
    assign io_disp.frame_start = r_frame_start;
    assign io_disp.pending     = r_pending;

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan
//   Scoreboard bench for display_scan (4 digits, 8-cycle slots, 2 blank
//   cycles, blink half-period of 2 frames, active-low outputs). The stimulus
//   process queues the expected appearance of every lit digit slot; the
//   monitor pops one entry at the first lit cycle of each slot.
module tb_display_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    display_scan_if #(.NUM_DIGITS(4)) bus ();

    display_scan #(
        .NUM_DIGITS(4),
        .SCAN_DIV(8),
        .BLANK_CYCLES(2),
        .BLINK_FRAMES(2),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .io_disp(bus)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       pend;
        int         fs;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   t       = 0;

    // Active-low segment patterns
    localparam logic [6:0] S_BLK = 7'h7F;
    localparam logic [6:0] S_0   = 7'h01;
    localparam logic [6:0] S_1   = 7'h4F;
    localparam logic [6:0] S_2   = 7'h12;
    localparam logic [6:0] S_3   = 7'h06;
    localparam logic [6:0] S_4   = 7'h4C;
    localparam logic [6:0] S_5   = 7'h24;
    localparam logic [6:0] S_6   = 7'h20;
    localparam logic [6:0] S_7   = 7'h0F;
    localparam logic [6:0] S_G   = 7'h21;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // dpn: expected dp output per digit (active-low); pend: pending per slot
    task automatic push_frame(input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0,
                              input logic [3:0] dpn, input logic [3:0] pend);
        logic [6:0] s [4];
        exp_t e;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int d = 0; d < 4; d++) begin
            e.an   = ~(4'b0001 << d);
            e.seg  = s[d];
            e.dp   = dpn[d];
            e.pend = pend[d];
            e.fs   = (d == 0) ? 1 : 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic goto(input int target);
        while (t < target) step();
    endtask

    task automatic load_now(input logic [19:0] g, input logic [3:0] dpi, input logic [3:0] bli);
        bus.glyphs   = g;
        bus.dp_in    = dpi;
        bus.blink_in = bli;
        bus.load     = 1'b1;
        step();
        bus.load     = 1'b0;
    endtask

    // Monitor
    logic rst_d    = 1'b1;
    logic prev_lit = 1'b0;
    int   cyc      = 0;
    int   lit_len  = 0;
    int   fs_cnt   = 0;

    always @(negedge clk) begin
        logic lit;
        exp_t e;
        if (rst_d) begin
            check("reset_outputs",
                  32'({bus.an, bus.seg, bus.dp, bus.frame_start, bus.pending}),
                  32'({4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}));
            cyc      = 0;
            prev_lit = 1'b0;
            lit_len  = 0;
            fs_cnt   = 0;
        end else begin
            cyc++;
            if (bus.frame_start) fs_cnt++;
            lit = (bus.an != 4'hF);
            if (lit && !prev_lit) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_slot", 32'(bus.an), 32'hF);
                end else begin
                    e = exp_q.pop_front();
                    check("an",          32'(bus.an),      32'(e.an));
                    check("seg",         32'(bus.seg),     32'(e.seg));
                    check("dp",          32'(bus.dp),      32'(e.dp));
                    check("pending",     32'(bus.pending), 32'(e.pend));
                    check("frame_start", 32'(fs_cnt),      32'(e.fs));
                    check("slot_phase",  32'(cyc % 8),     32'd3);
                end
                fs_cnt  = 0;
                lit_len = 0;
            end
            if (lit) lit_len++;
            if (!lit && prev_lit) check("lit_length", 32'(lit_len), 32'd6);
            prev_lit = lit;
        end
        rst_d = rst;
    end

    initial begin
        bus.load     = 1'b0;
        bus.glyphs   = '0;
        bus.dp_in    = '0;
        bus.blink_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        t   = 0;

        // Frame 0: blank after reset
        push_frame(S_BLK, S_BLK, S_BLK, S_BLK, 4'hF, 4'b0000);
        goto(32);

        // Frame 1: mid-frame load stays in shadow
        push_frame(S_BLK, S_BLK, S_BLK, S_BLK, 4'hF, 4'b1100);
        goto(44);
        load_now({5'd3, 5'd2, 5'd1, 5'd0}, 4'b0010, 4'b0000);
        goto(64);

        // Frame 2: committed data; two loads, last wins
        push_frame(S_3, S_2, S_1, S_0, 4'b1101, 4'b1110);
        goto(69);
        load_now({4{5'd8}}, 4'b0000, 4'b0000);
        goto(84);
        load_now({4{5'd17}}, 4'b0000, 4'b0000);
        goto(96);

        // Frame 3: all G; load on the boundary cycle
        push_frame(S_G, S_G, S_G, S_G, 4'hF, 4'b0000);
        goto(127);
        load_now({5'd4, 5'd5, 5'd6, 5'd7}, 4'b1001, 4'b0000);

        // Frame 4: boundary load visible at once, never pending
        push_frame(S_4, S_5, S_6, S_7, 4'b0110, 4'b1110);
        goto(137);
        load_now({4{5'd5}}, 4'b0000, 4'b0001);
        goto(160);

        // Frames 5..8: digit 0 blinks, phase on/off/off/on
        push_frame(S_5, S_5, S_5, S_5,   4'hF, 4'b0000);
        goto(192);
        push_frame(S_5, S_5, S_5, S_BLK, 4'hF, 4'b0000);
        goto(224);
        push_frame(S_5, S_5, S_5, S_BLK, 4'hF, 4'b0000);
        goto(256);
        push_frame(S_5, S_5, S_5, S_5,   4'hF, 4'b1110);
        goto(261);
        load_now({4{5'd8}}, 4'b1111, 4'b0000);

        // Reset while digit 2 is lit and data is pending
        goto(276);
        rst = 1'b1;
        exp_q.delete();
        step();
        step();
        step();
        rst = 1'b0;
        t   = 0;

        // Pending data discarded: blank frames follow
        push_frame(S_BLK, S_BLK, S_BLK, S_BLK, 4'hF, 4'b0000);
        push_frame(S_BLK, S_BLK, S_BLK, S_BLK, 4'hF, 4'b0000);
        goto(64);
        step();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
